// File: rtl/pmem_burst_responder.sv
// pmem_burst_responder
// Memory-side model of the 64-bit burst pmem interface. A 256-bit line is
// moved as four 64-bit beats, starting a programmable number of cycles
// after the request is accepted. Storage is one 64-bit word per beat,
// addressed as {line index, beat}, so beat 0 is the lowest address.
module pmem_burst_responder #(
  parameter int LINE_IDX_BITS = 10,
  parameter int LATENCY       = 8,
  parameter int BURST_LEN     = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pmem_read,
  input  logic        pmem_write,
  input  logic [31:0] pmem_address,
  input  logic [63:0] pmem_wdata,
  output logic [63:0] pmem_rdata,
  output logic        pmem_resp,
  output logic        proto_err
);

  localparam int DEPTH = (1 << LINE_IDX_BITS) * 4;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    BURST,
    DONE
  } state_t;

  state_t                   state;
  logic [LINE_IDX_BITS-1:0] idx;
  logic                     is_write;
  logic [7:0]               wait_cnt;
  logic [1:0]               beat;
  logic [1:0]               next_beat;
  logic                     req_held;
  logic                     mem_we;
  logic [63:0]              mem [DEPTH];

  // Address bits outside the line index are deliberately ignored (aliasing).
  logic unused_addr;
  assign unused_addr = ^{pmem_address[31:5+LINE_IDX_BITS], pmem_address[4:0]};

  assign next_beat = beat + 2'd1;

  // The latched op decides which request line must stay high until the last beat.
  assign req_held = is_write ? pmem_write : pmem_read;

  // Reset blocks the commit of a write beat on the edge where it is sampled.
  assign mem_we = (state == BURST) && is_write && !rst;

  // Line storage: write beats commit at the edge ending each resp cycle; never reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[{idx, beat}] <= pmem_wdata;
    end
  end

  // Transaction FSM with registered resp/rdata and the sticky protocol flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      pmem_resp  <= 1'b0;
      pmem_rdata <= '0;
      proto_err  <= 1'b0;
      wait_cnt   <= '0;
      beat       <= '0;
      idx        <= '0;
      is_write   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pmem_read || pmem_write) begin
            idx      <= pmem_address[5+LINE_IDX_BITS-1:5];
            is_write <= pmem_write && !pmem_read;
            if (pmem_read && pmem_write) begin
              proto_err <= 1'b1;
            end
            wait_cnt <= 8'(LATENCY - 1);
            state    <= WAIT;
          end
        end
        WAIT: begin
          if (!req_held) begin
            proto_err <= 1'b1;
          end
          if (wait_cnt == 8'd0) begin
            state      <= BURST;
            beat       <= 2'd0;
            pmem_resp  <= 1'b1;
            pmem_rdata <= is_write ? 64'd0 : mem[{idx, 2'd0}];
          end else begin
            wait_cnt <= wait_cnt - 8'd1;
          end
        end
        BURST: begin
          if (!req_held) begin
            proto_err <= 1'b1;
          end
          if (beat == 2'(BURST_LEN - 1)) begin
            state      <= DONE;
            beat       <= 2'd0;
            pmem_resp  <= 1'b0;
            pmem_rdata <= '0;
          end else begin
            beat       <= next_beat;
            pmem_rdata <= is_write ? 64'd0 : mem[{idx, next_beat}];
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pmem_burst_responder.sv
// tb_pmem_burst_responder
// Directed bench: line writes/reads, latency, back-to-back, aliasing,
// protocol violations and reset in the middle of a write burst.
module tb_pmem_burst_responder;

  localparam int LAT = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        pmem_read;
  logic        pmem_write;
  logic [31:0] pmem_address;
  logic [63:0] pmem_wdata;
  logic [63:0] pmem_rdata;
  logic        pmem_resp;
  logic        proto_err;

  int n_checks = 0;
  int n_fail   = 0;

  pmem_burst_responder #(
    .LINE_IDX_BITS(10),
    .LATENCY(LAT),
    .BURST_LEN(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .pmem_read(pmem_read),
    .pmem_write(pmem_write),
    .pmem_address(pmem_address),
    .pmem_wdata(pmem_wdata),
    .pmem_rdata(pmem_rdata),
    .pmem_resp(pmem_resp),
    .proto_err(proto_err)
  );

  // Free-running clock, 10 time units per cycle.
  always #5 clk = ~clk;

  // Hard stop in case the sequence itself gets stuck.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: observed no end of test, expected $finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // One comparison: counts it, and on mismatch counts and reports it.
  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Runs one line transaction from a negedge. first_lat counts edges from the
  // accepting edge to the edge that raises the first beat. drop_cyc releases
  // the request after that many edges; abort_beat raises rst when that beat
  // would appear. With hold set, the request is left high and the task
  // returns in the turnaround cycle; otherwise it returns with the FSM idle.
  task automatic applyStimulus(input logic rd, input logic wr, input logic [31:0] addr,
                               input logic [3:0][63:0] wd, input int drop_cyc,
                               input int abort_beat, input bit hold,
                               output logic [3:0][63:0] rdv, output int first_lat,
                               output int nbeats, output int span, output logic tail_resp);
    int cyc;
    int last_cyc;
    bit aborted;
    cyc       = 0;
    last_cyc  = -1;
    aborted   = 1'b0;
    first_lat = -1;
    nbeats    = 0;
    rdv       = '0;
    tail_resp = 1'bx;
    pmem_read    = rd;
    pmem_write   = wr;
    pmem_address = addr;
    pmem_wdata   = '0;
    while (nbeats < 4 && cyc < 300 && !aborted) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      if (cyc == drop_cyc) begin
        pmem_read  = 1'b0;
        pmem_write = 1'b0;
      end
      if (pmem_resp) begin
        if (nbeats == abort_beat) begin
          rst        = 1'b1;
          pmem_read  = 1'b0;
          pmem_write = 1'b0;
          aborted    = 1'b1;
        end else begin
          if (first_lat < 0) first_lat = cyc - 1;
          last_cyc     = cyc - 1;
          rdv[nbeats]  = pmem_rdata;
          pmem_wdata   = wd[nbeats];
          nbeats++;
        end
      end
    end
    span = last_cyc - first_lat;
    if (!aborted) begin
      @(posedge clk);
      @(negedge clk);
      tail_resp = pmem_resp;
      if (!hold) begin
        pmem_read  = 1'b0;
        pmem_write = 1'b0;
        @(posedge clk);
        @(negedge clk);
      end
    end
  endtask

  logic [3:0][63:0] a_line, c_line, b_line, d_line, junk, zero_line, rdv, exp_line;
  int   first_lat, nbeats, span;
  logic tail_resp;

  initial begin
    a_line    = {64'hA3A3_0003_1111_0003, 64'hA2A2_0002_1111_0002,
                 64'hA1A1_0001_1111_0001, 64'hA0A0_0000_1111_0000};
    b_line    = {64'hB3B3_3333_0000_BBB3, 64'hB2B2_2222_0000_BBB2,
                 64'hB1B1_1111_0000_BBB1, 64'hB0B0_0000_0000_BBB0};
    c_line    = {64'hC3C3_C3C3_C3C3_C3C3, 64'hC2C2_C2C2_C2C2_C2C2,
                 64'hC1C1_C1C1_C1C1_C1C1, 64'hC0C0_C0C0_C0C0_C0C0};
    d_line    = {64'hDDDD_0000_0000_0003, 64'hDDDD_0000_0000_0002,
                 64'hDDDD_0000_0000_0001, 64'hDDDD_0000_0000_0000};
    junk      = {64'hFFFF_FFFF_FFFF_FFFF, 64'hEEEE_EEEE_EEEE_EEEE,
                 64'h5555_5555_5555_5555, 64'h1234_5678_9ABC_DEF0};
    zero_line = '0;

    // Reset state
    rst = 1'b1; pmem_read = 1'b0; pmem_write = 1'b0;
    pmem_address = '0; pmem_wdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_resp", 64'(pmem_resp), 64'd0);
    checkOutput("reset_rdata", pmem_rdata, 64'd0);
    checkOutput("reset_proto_err", 64'(proto_err), 64'd0);
    rst = 1'b0;

    // Write line 0x40, then read it back; also checks latency and burst shape
    applyStimulus(1'b0, 1'b1, 32'h0000_0040, a_line, -1, -1, 1'b0,
                  rdv, first_lat, nbeats, span, tail_resp);
    checkOutput("wr_beats", 64'(nbeats), 64'd4);
    checkOutput("wr_latency", 64'(first_lat), 64'(LAT));
    checkOutput("wr_rdata_zero", rdv, zero_line);
    applyStimulus(1'b1, 1'b0, 32'h0000_0040, zero_line, -1, -1, 1'b0,
                  rdv, first_lat, nbeats, span, tail_resp);
    checkOutput("rd_beats", 64'(nbeats), 64'd4);
    checkOutput("rd_latency", 64'(first_lat), 64'(LAT));
    checkOutput("rd_consecutive", 64'(span), 64'd3);
    checkOutput("rd_resp_low_after", 64'(tail_resp), 64'd0);
    for (int k = 0; k < 4; k++) begin
      checkOutput($sformatf("rd_beat%0d", k), rdv[k], a_line[k]);
    end
    checkOutput("rd_proto_err", 64'(proto_err), 64'd0);

    // Back-to-back reads with pmem_read held across both lines
    applyStimulus(1'b1, 1'b0, 32'h0000_0040, zero_line, -1, -1, 1'b1,
                  rdv, first_lat, nbeats, span, tail_resp);
    checkOutput("b2b_first_data", rdv, a_line);
    checkOutput("b2b_first_tail", 64'(tail_resp), 64'd0);
    applyStimulus(1'b1, 1'b0, 32'h0000_0040, zero_line, -1, -1, 1'b0,
                  rdv, first_lat, nbeats, span, tail_resp);
    checkOutput("b2b_gap", 64'(first_lat), 64'(LAT + 1));
    checkOutput("b2b_second_data", rdv, a_line);
    checkOutput("b2b_proto_err", 64'(proto_err), 64'd0);

    // Alias: 0x8000 maps onto the same line as 0x0000
    applyStimulus(1'b0, 1'b1, 32'h0000_0000, d_line, -1, -1, 1'b0,
                  rdv, first_lat, nbeats, span, tail_resp);
    applyStimulus(1'b1, 1'b0, 32'h0000_8000, zero_line, -1, -1, 1'b0,
                  rdv, first_lat, nbeats, span, tail_resp);
    checkOutput("alias_data", rdv, d_line);
    checkOutput("alias_proto_err", 64'(proto_err), 64'd0);

    // Request dropped during WAIT: burst still completes, flag sticks
    applyStimulus(1'b1, 1'b0, 32'h0000_0040, zero_line, 3, -1, 1'b0,
                  rdv, first_lat, nbeats, span, tail_resp);
    checkOutput("drop_beats", 64'(nbeats), 64'd4);
    checkOutput("drop_data", rdv, a_line);
    checkOutput("drop_proto_err", 64'(proto_err), 64'd1);
    applyStimulus(1'b1, 1'b0, 32'h0000_0000, zero_line, -1, -1, 1'b0,
                  rdv, first_lat, nbeats, span, tail_resp);
    checkOutput("drop_recover_latency", 64'(first_lat), 64'(LAT));
    checkOutput("drop_recover_data", rdv, d_line);

    // Read and write together: served as a read, array untouched
    applyStimulus(1'b1, 1'b1, 32'h0000_0040, junk, -1, -1, 1'b0,
                  rdv, first_lat, nbeats, span, tail_resp);
    checkOutput("both_data", rdv, a_line);
    checkOutput("both_proto_err", 64'(proto_err), 64'd1);
    applyStimulus(1'b1, 1'b0, 32'h0000_0040, zero_line, -1, -1, 1'b0,
                  rdv, first_lat, nbeats, span, tail_resp);
    checkOutput("both_array_unchanged", rdv, a_line);
    checkOutput("both_proto_err_sticky", 64'(proto_err), 64'd1);

    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    checkOutput("rst_clears_proto_err", 64'(proto_err), 64'd0);

    // Reset after beat 1 of a write: beats 0..1 new, beats 2..3 old
    applyStimulus(1'b0, 1'b1, 32'h0000_0080, c_line, -1, -1, 1'b0,
                  rdv, first_lat, nbeats, span, tail_resp);
    applyStimulus(1'b0, 1'b1, 32'h0000_0080, b_line, -1, 2, 1'b0,
                  rdv, first_lat, nbeats, span, tail_resp);
    checkOutput("abort_beats_seen", 64'(nbeats), 64'd2);
    @(posedge clk);
    @(negedge clk);
    checkOutput("abort_resp_low", 64'(pmem_resp), 64'd0);
    checkOutput("abort_rdata_zero", pmem_rdata, 64'd0);
    rst = 1'b0;
    exp_line = {c_line[3], c_line[2], b_line[1], b_line[0]};
    applyStimulus(1'b1, 1'b0, 32'h0000_0080, zero_line, -1, -1, 1'b0,
                  rdv, first_lat, nbeats, span, tail_resp);
    checkOutput("abort_latency", 64'(first_lat), 64'(LAT));
    checkOutput("abort_readback", rdv, exp_line);
    checkOutput("abort_proto_err", 64'(proto_err), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
